// File: rtl/vcu118_clk_rst_seq_pkg.sv
// Shared types and sizing helpers for the VCU118 clock/reset sequencer.
package vcu118_clk_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_MMCM_RST    = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_IDLY_RST    = 3'd3,
        ST_WAIT_RDY    = 3'd4,
        ST_RUN         = 3'd5,
        ST_FAULT       = 3'd6
    } seq_state_e;

    localparam int unsigned LOSS_CNT_W  = 8;
    localparam int unsigned RETRY_CNT_W = 4;

    // Down-counter holds at most max_cycles-1, so clog2(max_cycles) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned max_cycles);
        return (max_cycles <= 32'd2) ? 32'd1 : 32'($clog2(max_cycles));
    endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module cdc_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vcu118_clk_rst_sequencer.sv
// MMCM / IDELAYCTRL power-up and recovery sequencer running on the free-running input clock.
module vcu118_clk_rst_sequencer
    import vcu118_clk_rst_seq_pkg::*;
#(
    parameter int unsigned MMCM_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned IDELAY_RST_CYCLES   = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned RDY_TIMEOUT_CYCLES  = 4096,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  mmcm_locked,
    input  logic                  idelay_rdy,
    input  logic                  soft_rst_req,
    output logic                  mmcm_rst,
    output logic                  idelay_rst,
    output logic                  user_rst,
    output logic                  ready,
    output logic                  fault,
    output logic [2:0]            state_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned MAX_A   = (MMCM_RST_CYCLES > LOCK_STABLE_CYCLES) ? MMCM_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_B   = (IDELAY_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? IDELAY_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > RDY_TIMEOUT_CYCLES) ? MAX_AB : RDY_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(MAX_CYC);

    logic                   locked_s;
    logic                   rdy_s;
    seq_state_e             state;
    seq_state_e             state_nxt;
    logic                   armed;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [RETRY_CNT_W-1:0] retry_cnt;
    logic [RETRY_CNT_W-1:0] retry_nxt;
    logic [RETRY_CNT_W-1:0] retry_inc;
    logic [LOSS_CNT_W-1:0]  loss_nxt;
    logic                   expired;
    logic                   enter;
    logic                   timeout;

    cdc_sync_2ff u_sync_lock (.clk(sys_clk), .rst_n(sys_rst_n), .d(mmcm_locked), .q(locked_s));
    cdc_sync_2ff u_sync_rdy  (.clk(sys_clk), .rst_n(sys_rst_n), .d(idelay_rdy),  .q(rdy_s));

    // Counter load on state entry; a counted state lasts exactly N cycles.
    function automatic logic [CNT_W-1:0] load_val(input seq_state_e s);
        case (s)
            ST_MMCM_RST:    return CNT_W'(MMCM_RST_CYCLES - 1);
            ST_WAIT_LOCK:   return CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
            ST_LOCK_STABLE: return CNT_W'(LOCK_STABLE_CYCLES - 1);
            ST_IDLY_RST:    return CNT_W'(IDELAY_RST_CYCLES - 1);
            ST_WAIT_RDY:    return CNT_W'(RDY_TIMEOUT_CYCLES - 1);
            default:        return '0;
        endcase
    endfunction

    assign expired   = (cnt == '0);
    assign retry_inc = retry_cnt + 1'b1;
    assign state_o   = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = expired ? cnt : cnt - 1'b1;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        enter     = 1'b0;
        timeout   = 1'b0;

        // The reset state mirrors MMCM_RST but its counter is only loaded on the first edge.
        if (!armed) begin
            state_nxt = ST_MMCM_RST;
            enter     = 1'b1;
        end else begin
            case (state)
                ST_MMCM_RST: begin
                    if (expired) begin state_nxt = ST_WAIT_LOCK; enter = 1'b1; end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s)     begin state_nxt = ST_LOCK_STABLE; enter = 1'b1; end
                    else if (expired) timeout = 1'b1;
                end
                ST_LOCK_STABLE: begin
                    if (!locked_s)    begin state_nxt = ST_MMCM_RST; enter = 1'b1; end
                    else if (expired) begin state_nxt = ST_IDLY_RST; enter = 1'b1; end
                end
                ST_IDLY_RST: begin
                    if (!locked_s)    begin state_nxt = ST_MMCM_RST; enter = 1'b1; end
                    else if (expired) begin state_nxt = ST_WAIT_RDY; enter = 1'b1; end
                end
                ST_WAIT_RDY: begin
                    if (!locked_s) begin
                        state_nxt = ST_MMCM_RST;
                        enter     = 1'b1;
                    end else if (rdy_s) begin
                        state_nxt = ST_RUN;
                        enter     = 1'b1;
                        retry_nxt = '0;
                    end else if (expired) begin
                        timeout = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_nxt = ST_MMCM_RST;
                        enter     = 1'b1;
                        if (lock_loss_cnt != '1) loss_nxt = lock_loss_cnt + 1'b1;
                    end else if (soft_rst_req) begin
                        state_nxt = ST_MMCM_RST;
                        enter     = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (soft_rst_req) begin
                        state_nxt = ST_MMCM_RST;
                        enter     = 1'b1;
                        retry_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_MMCM_RST;
                    enter     = 1'b1;
                end
            endcase
        end

        if (timeout) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RETRY_CNT_W'(MAX_RETRIES)) ? ST_FAULT : ST_MMCM_RST;
            enter     = 1'b1;
        end

        if (enter) cnt_nxt = load_val(state_nxt);
    end

    // State, counters and outputs decoded from the next state so they switch together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_MMCM_RST;
            armed         <= 1'b0;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            mmcm_rst      <= 1'b1;
            idelay_rst    <= 1'b1;
            user_rst      <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            armed         <= 1'b1;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            mmcm_rst      <= (state_nxt == ST_MMCM_RST) || (state_nxt == ST_FAULT);
            idelay_rst    <= (state_nxt != ST_WAIT_RDY) && (state_nxt != ST_RUN);
            user_rst      <= (state_nxt != ST_RUN);
            ready         <= (state_nxt == ST_RUN);
            fault         <= (state_nxt == ST_FAULT);
        end
    end

endmodule
